// File: rtl/simd_sat_addsub_pipe_pkg.sv
// Shared encodings and segment helpers for the SIMD saturating add/sub pipeline.
package simd_sat_addsub_pipe_pkg;

   localparam int MAX_LANES = 64;

   typedef enum logic [1:0] {
      SAT_WRAP     = 2'b00,
      SAT_SIGNED   = 2'b01,
      SAT_UNSIGNED = 2'b10
   } sat_mode_e;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Bit i set when base lane i is the lowest lane of its segment; width saturates at lane_lg.
   function automatic logic [MAX_LANES-1:0] seg_base_mask(input logic [1:0] width,
                                                          input int lane_lg,
                                                          input int num_lanes);
      logic [MAX_LANES-1:0] mask;
      int sh;
      sh   = (int'(width) > lane_lg) ? lane_lg : int'(width);
      mask = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if ((i < num_lanes) && ((i & ((1 << sh) - 1)) == 0)) mask[i] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/simd_sat_addsub_pipe_lane_add.sv
// One base lane of the chained adder: sum, carry-out and signed overflow.
module simd_sat_addsub_pipe_lane_add
   import simd_sat_addsub_pipe_pkg::*;
#(
   parameter int LANE_W = 8
) (
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   input  logic              cin,
   output logic [LANE_W-1:0] sum,
   output logic              cout,
   output logic              ovf
);

   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin};
      ovf         = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
   end

endmodule

// File: rtl/simd_sat_addsub_pipe.sv
// Two-stage SIMD add/subtract with per-segment wrap, signed or unsigned saturation.
module simd_sat_addsub_pipe
   import simd_sat_addsub_pipe_pkg::*;
#(
   parameter int LANE_W    = 8,
   parameter int NUM_LANES = 4,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANE_W*NUM_LANES-1:0] a,
   input  logic [LANE_W*NUM_LANES-1:0] b,
   input  logic [1:0]                width,
   input  logic                      op,
   input  logic [1:0]                sat_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANE_W*NUM_LANES-1:0] out_data,
   output logic [NUM_LANES-1:0]      out_sat,
   input  logic                      sat_clr,
   output logic [CNT_W-1:0]          sat_count
);

   localparam int DW      = LANE_W * NUM_LANES;
   localparam int LANE_LG = $clog2(NUM_LANES);

   logic                 ready1, ready2;
   logic                 vld_p1, vld_p2;
   logic [NUM_LANES-1:0] base, top;
   logic [DW-1:0]        b_eff, sum;
   logic [NUM_LANES-1:0] cout, ovf;
   logic [NUM_LANES-1:0] seg_c, seg_v, seg_s;
   logic                 c_run, v_run, s_run;

   logic [DW-1:0]        sum_p1;
   logic [NUM_LANES-1:0] seg_c_p1, seg_v_p1, seg_s_p1, top_p1;
   logic [1:0]           mode_p1;
   logic                 op_p1;

   logic [DW-1:0]        sat_data;
   logic [NUM_LANES-1:0] sat_flags;

   assign ready2    = !vld_p2 || out_ready;
   assign ready1    = !vld_p1 || ready2;
   assign in_ready  = ready1;
   assign out_valid = vld_p2;

   always_comb begin
      base  = NUM_LANES'(seg_base_mask(width, LANE_LG, NUM_LANES));
      b_eff = (op == OP_SUB) ? ~b : b;
   end

   // Stage 1: carry chain, killed at segment boundaries by re-injecting the op carry.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic c_in, c_out;
      if (i == 0) begin : g_first
         assign c_in = base[0] & op;
      end else begin : g_chain
         assign c_in = base[i] ? op : g_lane[i-1].c_out;
      end
      if (i == NUM_LANES - 1) begin : g_top
         assign top[i] = 1'b1;
      end else begin : g_mid
         assign top[i] = base[i+1];
      end
      simd_sat_addsub_pipe_lane_add #(.LANE_W(LANE_W)) u_lane_add (
         .a    (a[i*LANE_W +: LANE_W]),
         .b    (b_eff[i*LANE_W +: LANE_W]),
         .cin  (c_in),
         .sum  (sum[i*LANE_W +: LANE_W]),
         .cout (c_out),
         .ovf  (ovf[i])
      );
      assign cout[i] = c_out;
   end

   // Broadcast each segment's top-lane carry, overflow and a-sign down to all its lanes.
   always_comb begin
      c_run = 1'b0;
      v_run = 1'b0;
      s_run = 1'b0;
      seg_c = '0;
      seg_v = '0;
      seg_s = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (top[i]) begin
            c_run = cout[i];
            v_run = ovf[i];
            s_run = a[i*LANE_W + LANE_W - 1];
         end
         seg_c[i] = c_run;
         seg_v[i] = v_run;
         seg_s[i] = s_run;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else if (ready1) vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (ready1 && in_valid) begin
         sum_p1   <= sum;
         seg_c_p1 <= seg_c;
         seg_v_p1 <= seg_v;
         seg_s_p1 <= seg_s;
         top_p1   <= top;
         mode_p1  <= sat_mode;
         op_p1    <= op;
      end
   end

   // Returns {saturated, lane value}; the segment's top lane carries the signed MSB pattern.
   function automatic logic [LANE_W:0] sat_lane(input logic [LANE_W-1:0] raw,
                                                input logic [1:0] mode,
                                                input logic sub, c, v, s, is_top);
      logic [LANE_W:0] r;
      r = {1'b0, raw};
      if (mode == SAT_SIGNED && v)
         r = {1'b1, is_top ? {s, {(LANE_W-1){!s}}} : {LANE_W{!s}}};
      else if (mode == SAT_UNSIGNED && sub == OP_ADD && c)
         r = {1'b1, {LANE_W{1'b1}}};
      else if (mode == SAT_UNSIGNED && sub == OP_SUB && !c)
         r = {1'b1, {LANE_W{1'b0}}};
      return r;
   endfunction

   // Stage 2: saturate per lane using the segment-wide flags.
   always_comb begin
      sat_data  = '0;
      sat_flags = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         {sat_flags[i], sat_data[i*LANE_W +: LANE_W]} =
            sat_lane(sum_p1[i*LANE_W +: LANE_W], mode_p1, op_p1,
                     seg_c_p1[i], seg_v_p1[i], seg_s_p1[i], top_p1[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2   <= 1'b0;
         out_data <= '0;
         out_sat  <= '0;
      end else if (ready2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            out_data <= sat_data;
            out_sat  <= sat_flags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || sat_clr)
         sat_count <= '0;
      else if (out_valid && out_ready && (|out_sat) && (sat_count != {CNT_W{1'b1}}))
         sat_count <= sat_count + 1'b1;
   end

endmodule

// File: tb/tb_simd_sat_addsub_pipe.sv
// Directed bench for simd_sat_addsub_pipe (LANE_W=8, NUM_LANES=4, CNT_W=2).
module tb_simd_sat_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic [1:0]  width;
   logic        op;
   logic [1:0]  sat_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_sat;
   logic        sat_clr;
   logic [1:0]  sat_count;

   int n_cmp = 0;
   int n_bad = 0;

   simd_sat_addsub_pipe #(.LANE_W(8), .NUM_LANES(4), .CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .width     (width),
      .op        (op),
      .sat_mode  (sat_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] w, input logic o, input logic [1:0] m,
                        input logic [31:0] av, input logic [31:0] bv);
      width = w; op = o; sat_mode = m; a = av; b = bv; in_valid = 1'b1;
   endtask

   task automatic beat(input string tag, input logic [1:0] w, input logic o,
                       input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv);
      drive(w, o, m, av, bv);
      #1;
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] d, input logic [3:0] s);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_data"}, out_data, d);
      chk({tag, "_sat"}, {28'd0, out_sat}, {28'd0, s});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; width = '0; op = 1'b0;
      sat_mode = 2'b00; out_ready = 1'b1; sat_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_sat", {28'd0, out_sat}, 32'd0);
      chk("rst_sat_count", {30'd0, sat_count}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Signed lanes: 2-cycle latency
      beat("t1", 2'd0, 1'b0, 2'b01, 32'h7F8010FF, 32'h01FF1001);
      chk("t1_lat", {31'd0, out_valid}, 32'd0);
      tick();
      expect_out("t1", 32'h7F802000, 4'b1100);

      // Full-width unsigned then the same beat in wrap, back to back
      beat("t2a", 2'd2, 1'b0, 2'b10, 32'hFFFFFFF0, 32'h00000020);
      beat("t2b", 2'd2, 1'b0, 2'b00, 32'hFFFFFFF0, 32'h00000020);
      expect_out("t2a", 32'hFFFFFFFF, 4'b1111);
      tick();
      expect_out("t2b", 32'h00000010, 4'b0000);

      // Unsigned subtract on 16-bit segments
      beat("t3", 2'd1, 1'b1, 2'b10, 32'h00010005, 32'h00020003);
      tick();
      expect_out("t3", 32'h00000002, 4'b1100);

      // Width code 3 is full width; signed subtract on 16-bit segments
      beat("t4", 2'd3, 1'b0, 2'b01, 32'h7FFFFFFF, 32'h00000001);
      beat("t5", 2'd1, 1'b1, 2'b01, 32'h80000005, 32'h00010007);
      expect_out("t4", 32'h7FFFFFFF, 4'b1111);
      tick();
      expect_out("t5", 32'h8000FFFE, 4'b1100);
      tick();
      chk("t5_drained", {31'd0, out_valid}, 32'd0);
      chk("cnt_hold_max", {30'd0, sat_count}, 32'd3);

      // Backpressure: three beats offered with out_ready low
      out_ready = 1'b0;
      drive(2'd0, 1'b0, 2'b00, 32'h00000001, 32'h10101010);
      #1 chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
      tick();
      drive(2'd0, 1'b0, 2'b00, 32'h00000002, 32'h10101010);
      #1 chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
      tick();
      drive(2'd0, 1'b0, 2'b00, 32'h00000003, 32'h10101010);
      #1 chk("bp_rdy_full", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_rdy_still", {31'd0, in_ready}, 32'd0);
      expect_out("bp_hold0", 32'h10101011, 4'b0000);
      tick();
      chk("bp_hold1_data", out_data, 32'h10101011);
      out_ready = 1'b1;
      #1 chk("bp_rdy_comb", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      expect_out("bp_d1", 32'h10101012, 4'b0000);
      tick();
      expect_out("bp_d2", 32'h10101013, 4'b0000);
      tick();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Reset with two beats in flight
      out_ready = 1'b0;
      beat("rf0", 2'd0, 1'b0, 2'b01, 32'h7F8010FF, 32'h01FF1001);
      beat("rf1", 2'd2, 1'b0, 2'b10, 32'hFFFFFFF0, 32'h00000020);
      chk("rf_full", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rf_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rf_out_data", out_data, 32'd0);
      chk("rf_count", {30'd0, sat_count}, 32'd0);
      chk("rf_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick();
      chk("rf_no_stale0", {31'd0, out_valid}, 32'd0);
      tick();
      chk("rf_no_stale1", {31'd0, out_valid}, 32'd0);

      // Counter saturates at 3 after five saturating transfers
      for (int i = 0; i < 5; i++) beat("cs", 2'd0, 1'b0, 2'b01, 32'h7F8010FF, 32'h01FF1001);
      tick(); tick(); tick();
      chk("cs_empty", {31'd0, out_valid}, 32'd0);
      chk("cs_count", {30'd0, sat_count}, 32'd3);

      // Clear coincident with a saturating transfer wins
      beat("clr", 2'd0, 1'b0, 2'b01, 32'h7F8010FF, 32'h01FF1001);
      tick();
      expect_out("clr", 32'h7F802000, 4'b1100);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      chk("clr_count", {30'd0, sat_count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/simd_sat_addsub_pipe.md
# simd_sat_addsub_pipe

Parametrised, pipelined SIMD add/subtract unit with per-segment saturation. It is the successor to the combinational 32-bit packed adder: lane count and lane width are parameters, subtraction is added, and signed and unsigned saturation are both supported. A two-stage valid/ready pipeline is added, along with per-lane saturation flags and a sticky saturation event counter. It sits in the datapath between the operand fetch stage and the writeback stage.

## Interface
- `LANE_W`, default 8: base lane width in bits.
- `NUM_LANES`, default 4: base lane count. Must be a power of two and ≥ 2. `DW = LANE_W*NUM_LANES`.
- `CNT_W`, default 16: width of `sat_count`.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `in_valid`, in, 1: an operand beat is present.
- `in_ready`, out, 1: the unit can accept the beat.
- `a`, `b`, in, DW: packed operands.
- `width`, in, 2: segment size code. Segment = `LANE_W << min(width, log2(NUM_LANES))`.
- `op`, in, 1: 0 = a+b, 1 = a−b.
- `sat_mode`, in, 2: 00 wrap, 01 signed saturate, 10 unsigned saturate, 11 treated as wrap.
- `out_valid`, out, 1: a result is present.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, DW: packed result.
- `out_sat`, out, NUM_LANES: per base lane, 1 if that lane's segment saturated.
- `sat_clr`, in, 1: clears `sat_count`.
- `sat_count`, out, CNT_W: count of transfers with any saturation. Saturates at all-ones.

## Operation
- **Transfers.**
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- **Stage 1 (chained add).**
  - `b` is inverted per bit when `op=1`, with carry-in 1 into the lowest lane of each segment.
  - Inter-lane carry propagates only inside a segment. It is killed at segment boundaries.
  - The stage registers the raw sum, the segment carry-out, the segment signed-overflow bit, `sat_mode` and `op`.
- **Stage 2 (saturate), applied per segment:**
  - Signed mode with overflow: result is 0111…1 if the operand a sign is 0, else 1000…0.
  - Unsigned add with carry-out 1: result is all-ones.
  - Unsigned sub with no carry-out (borrow): result is 0.
  - Wrap mode: raw sum is passed unchanged and `out_sat` = 0.
  - `out_sat` bits are set for every base lane in a saturated segment.
- **Control fields.** `width`, `op` and `sat_mode` are sampled per beat and travel with the data. Beats with different modes may be interleaved back to back.
- **Pipeline advance.**
  - Valid bits are `v1` and `v2`, with `ready2 = !v2 || out_ready` and `ready1 = !v1 || ready2`.
  - `in_ready = ready1`. This is a combinational path from `out_ready`, and it is permitted.
- **Counter.**
  - `sat_count` increments on an output transfer with `|out_sat`.
  - It holds at all-ones once reached.
  - If `sat_clr` and an increment occur in the same cycle, clear wins and the result is 0.

## Timing
- **Latency:** 2 cycles from the input transfer to `out_valid` when not stalled.
- **Throughput:** 1 beat/cycle.
- **Buffering:** 2 beats max. Results stay in order, with no drop or duplication.
- **Stable output:** `out_data` and `out_sat` hold stable while `out_valid && !out_ready`.
- **Reset values:**
  - `v1`, `v2`, `out_valid` = 0.
  - `out_data` = 0, `out_sat` = 0, `sat_count` = 0.
- **Reset mid-operation:** in-flight beats are discarded. `in_ready` is 1 in the first cycle after reset deasserts.
- **Full pipeline with `out_ready` low:** `in_ready` = 0. When `out_ready` rises, one beat drains and one enters in the same cycle.
- **Width code:** `width` ≥ log2(NUM_LANES) selects a single full-width segment.

## Structure
- A shared package holds:
  - `sat_mode` encodings (`SAT_WRAP`, `SAT_SIGNED`, `SAT_UNSIGNED`).
  - `op` encodings (`OP_ADD`, `OP_SUB`).
  - A function computing the segment-boundary mask from `width`, `LANE_W` and `NUM_LANES`.
- One sub-module is natural: `lane_add`.
  - Function: LANE_W-bit add with carry-in, carry-out and sign-overflow outputs.
  - Instantiation: NUM_LANES times in a generate loop.
  - Carry-in: a mux between the previous lane's carry and the segment base carry.
- The saturation logic and the pipeline registers live in the top module.

## Test plan
Defaults for all scenarios: LANE_W=8, NUM_LANES=4, `out_ready`=1 unless stated.

- **Signed lanes:** `width`=0, signed, add, `a`=0x7F8010FF, `b`=0x01FF1001 → `out_data`=0x7F802000, `out_sat`=4'b1100, 2 cycles after accept.
- **Full-width unsigned vs wrap:** `width`=2, add, `a`=0xFFFFFFF0, `b`=0x00000020.
  - Unsigned → 0xFFFFFFFF, `out_sat`=4'b1111.
  - Same beat in wrap → 0x00000010, `out_sat`=0.
- **Unsigned subtract:** `width`=1, sub, `a`=0x00010005, `b`=0x00020003 → 0x00000002, `out_sat`=4'b1100.
- **Backpressure:** `out_ready`=0 while 3 beats are offered.
  - Only 2 are accepted and `in_ready` drops.
  - After `out_ready`=1, all 3 emerge in order, with no gaps once steady.
- **Reset mid-flight:** 2 beats in flight, `rst` pulsed 1 cycle → `out_valid`=0 next cycle, no stale result ever appears, `sat_count`=0.
- **Counter saturation and clear:** CNT_W=2, 5 saturating transfers → `sat_count` holds 3.
  - `sat_clr` coincident with a saturating transfer → 0.
